srt_div_sched: RTL and testbench

Shares one pipelined 8-bit SRT divider core among NREQ requesters.
- Round-robin arbitration admits at most one division per cycle.
- A tag/valid pipeline runs matched to the core latency.
- Results go into an in-order response FIFO with credit-based flow control, because the core pipeline cannot stall.
- Divide-by-zero is detected and flagged without corrupting the core stream.

---
 rtl/srt_div_pkg.sv | 27 ++
 rtl/srt_div_sched_rr_arb.sv | 54 +++++
 rtl/srt_div_sched.sv | 162 ++++++++++++++++
 tb/tb_srt_div_sched.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/srt_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : srt_div_pkg
// Brief    : Shared types and constants for the SRT divider scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package srt_div_pkg;

  localparam int C_DIV_LAT   = 9;
  localparam int C_TAG_DW    = 8;
  localparam int C_TAG_ID_W  = 3;
  localparam logic [C_TAG_DW-1:0] C_DZ_QUO = '1;

  // Tag fields are sized for the largest supported configuration (NREQ<=8, DW<=8).
  typedef struct packed {
    logic                  valid;
    logic [C_TAG_ID_W-1:0] id;
    logic                  dz;
    logic [C_TAG_DW-1:0]   op1;
  } div_tag_t;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/srt_div_sched_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb
// Brief    : Round-robin arbiter; search starts after the last granted index.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb
  import srt_div_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] i_req,
  input  logic            i_en,
  input  logic            i_adv,
  output logic [NREQ-1:0] o_grant
);

  localparam int PTR_W = id_w(NREQ);

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_win;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    w_win   = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      w_idx = PTR_W'((int'(r_ptr) + i) % NREQ);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    if (i_en && w_found) o_grant[w_win] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= (w_win == PTR_W'(NREQ - 1)) ? '0 : w_win + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/srt_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : srt_div_sched
// Brief    : Shares one non-stallable pipelined divider among NREQ requesters.
// Revision : 1.0 - initial release
// ============================================================================
module srt_div_sched
  import srt_div_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int DW        = 8,
  parameter int DIV_LAT   = C_DIV_LAT,
  parameter int RSP_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid_i,
  output logic [NREQ-1:0]       req_ready_o,
  input  logic [NREQ*DW-1:0]    req_op1_i,
  input  logic [NREQ*DW-1:0]    req_op2_i,
  output logic [DW-1:0]         div_op1_o,
  output logic [DW-1:0]         div_op2_o,
  input  logic [DW-1:0]         div_rem_i,
  input  logic [DW-1:0]         div_quo_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [id_w(NREQ)-1:0] rsp_id_o,
  output logic [DW-1:0]         rsp_quo_o,
  output logic [DW-1:0]         rsp_rem_o,
  output logic                  rsp_dz_o,
  output logic                  busy_o
);

  localparam int ID_W  = id_w(NREQ);
  localparam int OCC_W = $clog2(RSP_DEPTH + 1);
  localparam int FP_W  = id_w(RSP_DEPTH);

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic            dz;
    logic [DW-1:0]   quo;
    logic [DW-1:0]   rem;
  } rsp_ent_t;

  logic [OCC_W-1:0] r_occ;
  logic [OCC_W-1:0] r_cnt;
  logic [FP_W-1:0]  r_wptr;
  logic [FP_W-1:0]  r_rptr;
  div_tag_t         r_tag [DIV_LAT+1];
  rsp_ent_t         r_mem [RSP_DEPTH];

  logic             w_issue_ok;
  logic             w_accept;
  logic             w_pop;
  logic [NREQ-1:0]  w_grant;
  logic [DW-1:0]    w_sel_op1;
  logic [DW-1:0]    w_sel_op2;
  logic [ID_W-1:0]  w_sel_id;
  div_tag_t         w_tag_in;
  div_tag_t         w_tag_out;
  rsp_ent_t         w_ent;
  rsp_ent_t         w_head;
  logic             w_unused_tag;

  // Credits cover both in-flight tags and queued entries, so the FIFO cannot overflow.
  assign w_issue_ok = (r_occ < OCC_W'(RSP_DEPTH));

  rr_arb #(.NREQ(NREQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   (req_valid_i),
    .i_en    (w_issue_ok),
    .i_adv   (w_accept),
    .o_grant (w_grant)
  );

  assign req_ready_o = w_grant;
  assign w_accept    = |(req_valid_i & w_grant);

  always_comb begin
    w_sel_op1 = '0;
    w_sel_op2 = '0;
    w_sel_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_grant[k]) begin
        w_sel_op1 = req_op1_i[k*DW +: DW];
        w_sel_op2 = req_op2_i[k*DW +: DW];
        w_sel_id  = ID_W'(k);
      end
    end
  end

  always_comb begin
    w_tag_in       = '0;
    w_tag_in.valid = w_accept;
    w_tag_in.id    = C_TAG_ID_W'(w_sel_id);
    w_tag_in.dz    = (w_sel_op2 == '0);
    w_tag_in.op1   = C_TAG_DW'(w_sel_op1);
  end

  // A zero divisor is replaced by 1 so the core never sees an undefined operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_op1_o <= '0;
      div_op2_o <= DW'(1);
    end else if (w_accept) begin
      div_op1_o <= w_sel_op1;
      div_op2_o <= (w_sel_op2 == '0) ? DW'(1) : w_sel_op2;
    end
  end

  // Stage DIV_LAT holds the tag during the cycle the core result is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s <= DIV_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= w_tag_in;
      for (int s = 1; s <= DIV_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  assign w_tag_out    = r_tag[DIV_LAT];
  assign w_unused_tag = ^w_tag_out.id;

  always_comb begin
    w_ent     = '0;
    w_ent.id  = ID_W'(w_tag_out.id);
    w_ent.dz  = w_tag_out.dz;
    w_ent.quo = w_tag_out.dz ? DW'(C_DZ_QUO) : div_quo_i;
    w_ent.rem = w_tag_out.dz ? DW'(w_tag_out.op1) : div_rem_i;
  end

  assign rsp_valid_o = (r_cnt != '0);
  assign w_pop       = rsp_valid_o & rsp_ready_i;

  always_ff @(posedge clk) begin
    if (w_tag_out.valid) r_mem[r_wptr] <= w_ent;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      r_occ  <= '0;
    end else begin
      if (w_tag_out.valid) r_wptr <= (r_wptr == FP_W'(RSP_DEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)           r_rptr <= (r_rptr == FP_W'(RSP_DEPTH - 1)) ? '0 : r_rptr + 1'b1;
      r_cnt <= r_cnt + OCC_W'(w_tag_out.valid) - OCC_W'(w_pop);
      r_occ <= r_occ + OCC_W'(w_accept) - OCC_W'(w_pop);
    end
  end

  assign w_head    = r_mem[r_rptr];
  assign rsp_id_o  = rsp_valid_o ? w_head.id  : '0;
  assign rsp_quo_o = rsp_valid_o ? w_head.quo : '0;
  assign rsp_rem_o = rsp_valid_o ? w_head.rem : '0;
  assign rsp_dz_o  = rsp_valid_o ? w_head.dz  : 1'b0;
  assign busy_o    = (r_occ != '0);

endmodule
`default_nettype wire

// File: tb/tb_srt_div_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_srt_div_sched
// Brief    : Scoreboard bench for srt_div_sched with a behavioural core model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_srt_div_sched;

  localparam int NREQ      = 4;
  localparam int DW        = 8;
  localparam int DIV_LAT   = 9;
  localparam int RSP_DEPTH = 4;
  localparam int ID_W      = 2;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [DW-1:0]   quo;
    logic [DW-1:0]   rem;
    logic            dz;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req_valid_i = '0;
  logic [NREQ-1:0]   req_ready_o;
  logic [NREQ*DW-1:0] req_op1_i = '0;
  logic [NREQ*DW-1:0] req_op2_i = '0;
  logic [DW-1:0]     div_op1_o, div_op2_o, div_rem_i, div_quo_i;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b1;
  logic [ID_W-1:0]   rsp_id_o;
  logic [DW-1:0]     rsp_quo_o, rsp_rem_o;
  logic              rsp_dz_o, busy_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];
  exp_t m_e, m_h;
  logic [DW-1:0] m_quo [DIV_LAT];
  logic [DW-1:0] m_rem [DIV_LAT];

  always #5 clk = ~clk;

  srt_div_sched #(.NREQ(NREQ), .DW(DW), .DIV_LAT(DIV_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op1_i(req_op1_i), .req_op2_i(req_op2_i),
    .div_op1_o(div_op1_o), .div_op2_o(div_op2_o),
    .div_rem_i(div_rem_i), .div_quo_i(div_quo_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_id_o(rsp_id_o), .rsp_quo_o(rsp_quo_o), .rsp_rem_o(rsp_rem_o),
    .rsp_dz_o(rsp_dz_o), .busy_o(busy_o)
  );

  // Core model: result valid DIV_LAT edges after the operand registers update.
  always @(posedge clk) begin
    m_quo[0] <= div_op1_o / div_op2_o;
    m_rem[0] <= div_op1_o % div_op2_o;
    for (int s = 1; s < DIV_LAT; s++) begin
      m_quo[s] <= m_quo[s-1];
      m_rem[s] <= m_rem[s-1];
    end
  end
  assign div_quo_i = m_quo[DIV_LAT-1];
  assign div_rem_i = m_rem[DIV_LAT-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Monitor: sample mid-cycle; pushes and pops take effect at the following edge.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
    end else begin
      check("busy", {31'b0, busy_o}, {31'b0, sb.size() != 0});
      check("occ_bound", {31'b0, sb.size() <= RSP_DEPTH}, 32'd1);
      check("ready_onehot", {31'b0, $countones(req_ready_o) <= 1}, 32'd1);
      if (rsp_valid_o && rsp_ready_i) begin
        if (sb.size() == 0) begin
          check("unexpected_rsp", 32'd1, 32'd0);
        end else begin
          m_h = sb.pop_front();
          check("rsp_id",  {30'b0, rsp_id_o}, {30'b0, m_h.id});
          check("rsp_quo", {24'b0, rsp_quo_o}, {24'b0, m_h.quo});
          check("rsp_rem", {24'b0, rsp_rem_o}, {24'b0, m_h.rem});
          check("rsp_dz",  {31'b0, rsp_dz_o}, {31'b0, m_h.dz});
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid_i[k] && req_ready_o[k]) begin
          m_e.id  = ID_W'(k);
          m_e.dz  = (req_op2_i[k*DW +: DW] == 0);
          m_e.quo = m_e.dz ? 8'hFF : req_op1_i[k*DW +: DW] / req_op2_i[k*DW +: DW];
          m_e.rem = m_e.dz ? req_op1_i[k*DW +: DW] : req_op1_i[k*DW +: DW] % req_op2_i[k*DW +: DW];
          sb.push_back(m_e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_valid_i[k]        = 1'b1;
    req_op1_i[k*DW +: DW] = a;
    req_op2_i[k*DW +: DW] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    req_valid_i = '0;
    rsp_ready_i = 1'b1;
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy_o) done = 1;
      tick();
    end
    check("drain", {31'b0, done}, 32'd1);
  endtask

  // Run n cycles and return how many requests were accepted.
  task automatic count_acc(input int n, output int acc);
    acc = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      acc += $countones(req_valid_i & req_ready_o);
      tick();
    end
  endtask

  // Hold the current requests until n have been accepted (bounded).
  task automatic issue_n(input int n);
    int got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      got += $countones(req_valid_i & req_ready_o);
      tick();
    end
    req_valid_i = '0;
    check("issue_n", got, n);
  endtask

  initial begin
    int lat, acc, got, idx, seen;
    logic [NREQ-1:0] a;

    rst = 1'b1;
    tick();
    tick();
    check("rst_ready",   {28'b0, req_ready_o}, 32'd0);
    check("rst_op1",     {24'b0, div_op1_o}, 32'd0);
    check("rst_op2",     {24'b0, div_op2_o}, 32'd1);
    check("rst_rvalid",  {31'b0, rsp_valid_o}, 32'd0);
    check("rst_rsp",     {rsp_id_o, rsp_quo_o, rsp_rem_o, rsp_dz_o}, 32'd0);
    check("rst_busy",    {31'b0, busy_o}, 32'd0);
    rst = 1'b0;
    tick();

    // Single request, latency and golden result
    set_req(2, 8'd100, 8'd7);
    issue_n(1);
    check("op1_reg", {24'b0, div_op1_o}, 32'd100);
    check("op2_reg", {24'b0, div_op2_o}, 32'd7);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", lat, 32'd10);
    check("single_rsp", {rsp_id_o, rsp_quo_o, rsp_rem_o, rsp_dz_o},
          {2'd2, 8'd14, 8'd2, 1'b0});
    tick();
    drain();

    // Round-robin order from pointer 0 with all requesters valid
    do_reset();
    for (int k = 0; k < NREQ; k++) set_req(k, 8'd200, 8'(k + 1));
    got = 0;
    for (int c = 0; c < 300 && got < 8; c++) begin
      @(negedge clk);
      a = req_valid_i & req_ready_o;
      if (a != 0) begin
        idx = 0;
        for (int k = 0; k < NREQ; k++) if (a[k]) idx = k;
        check("rr_order", idx, got % NREQ);
        got++;
      end
      tick();
      if (a != 0) req_op1_i[idx*DW +: DW] = 8'(200 - 7 * got);
    end
    check("rr_count", got, 32'd8);
    drain();

    // Zero divisor between two ordinary requests
    set_req(0, 8'd90, 8'd9);
    set_req(1, 8'd55, 8'd0);
    set_req(2, 8'd77, 8'd5);
    seen = 0;
    for (int c = 0; c < 100 && req_valid_i != 0; c++) begin
      @(negedge clk);
      a = req_valid_i & req_ready_o;
      tick();
      req_valid_i = req_valid_i & ~a;
      if (a[1]) begin
        seen = 1;
        check("dz_op1", {24'b0, div_op1_o}, 32'd55);
        check("dz_op2", {24'b0, div_op2_o}, 32'd1);
      end
    end
    check("dz_seen", seen, 32'd1);
    drain();

    // Credit stall with consumer blocked, then a single-pop release
    rsp_ready_i = 1'b0;
    for (int k = 0; k < NREQ; k++) set_req(k, 8'(30 + 40 * k), 8'(3 + k));
    count_acc(40, acc);
    check("stall_accepts", acc, 32'd4);
    @(negedge clk);
    check("stall_ready", {28'b0, req_ready_o}, 32'd0);
    tick();
    rsp_ready_i = 1'b1;
    count_acc(1, acc);
    rsp_ready_i = 1'b0;
    count_acc(19, got);
    check("release_accepts", acc + got, 32'd1);
    drain();

    // Random traffic with consumer toggling every cycle
    for (int c = 0; c < 120; c++) begin
      rsp_ready_i = ~rsp_ready_i;
      req_valid_i = NREQ'($urandom_range(0, 15));
      for (int k = 0; k < NREQ; k++) begin
        req_op1_i[k*DW +: DW] = 8'($urandom_range(0, 255));
        req_op2_i[k*DW +: DW] = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      end
      tick();
    end
    drain();

    // Reset with work queued and in flight
    rsp_ready_i = 1'b0;
    set_req(0, 8'd120, 8'd11);
    set_req(3, 8'd99, 8'd0);
    issue_n(2);
    repeat (12) tick();
    set_req(1, 8'd64, 8'd8);
    set_req(2, 8'd13, 8'd4);
    issue_n(2);
    repeat (3) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_valid", {31'b0, rsp_valid_o}, 32'd0);
    check("post_rst_busy",  {31'b0, busy_o}, 32'd0);
    rsp_ready_i = 1'b1;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (rsp_valid_o) seen++;
    end
    check("stale_rsp", seen, 32'd0);
    tick();
    set_req(3, 8'd250, 8'd16);
    issue_n(1);
    lat = 0;
    @(negedge clk);
    while (!rsp_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("post_rst_rsp", {rsp_id_o, rsp_quo_o, rsp_rem_o, rsp_dz_o},
          {2'd3, 8'd15, 8'd10, 1'b0});
    tick();
    drain();
    check("sb_empty", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
